// File: rtl/md_hilo_ctrl.sv
// HI/LO sequencer for the external multiply/divide unit: launch, latency count,
// result capture into HI/LO, and execute-stage stall while an operation is in flight.
module md_hilo_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [1:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        mt_valid,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    input  logic        mf_valid,
    input  logic [63:0] unit_result,
    output logic        unit_start,
    output logic [1:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        stop,
    output logic        busy,
    output logic        md_complete,
    output logic [63:0] md_result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic        r_start;
    logic        r_complete;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_result;
    logic        w_accept;
    logic        w_mt_wr;
    logic        w_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (md_valid) w_next = S_RUN;
            S_RUN:  if (r_cnt == 6'd0) w_next = S_IDLE;
        endcase
    end

    // An MD issue takes the slot; a simultaneous MTHI/MTLO is dropped.
    always_comb begin
        w_accept = 1'b0;
        w_mt_wr  = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_accept = md_valid;
                w_mt_wr  = mt_valid & ~md_valid;
            end
            S_RUN: w_done = (r_cnt == 6'd0);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= 6'd0;
            r_start    <= 1'b0;
            r_complete <= 1'b0;
            r_op       <= 2'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_result   <= 64'd0;
        end else begin
            r_start    <= w_accept;
            r_complete <= w_done;
            if (w_accept) begin
                r_op  <= md_op;
                r_a   <= md_a;
                r_b   <= md_b;
                r_cnt <= md_op[1] ? DIV_LOAD : MUL_LOAD;
            end else if (r_state == S_RUN && r_cnt != 6'd0) begin
                r_cnt <= r_cnt - 6'd1;
            end
            if (w_done) begin
                r_hi     <= unit_result[63:32];
                r_lo     <= unit_result[31:0];
                r_result <= unit_result;
            end else if (w_mt_wr) begin
                if (mt_sel) begin
                    r_hi <= mt_data;
                end else begin
                    r_lo <= mt_data;
                end
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign stop        = busy & (md_valid | mf_valid | mt_valid);
    assign unit_start  = r_start;
    assign unit_op     = r_op;
    assign unit_a      = r_a;
    assign unit_b      = r_b;
    assign md_complete = r_complete;
    assign md_result   = r_result;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: doc/md_hilo_ctrl.md
# md_hilo_ctrl

Sequencing controller for the multiply/divide resource and the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU issues from the execute stage and launches the external arithmetic unit. It counts that unit's fixed latency, captures the 64-bit result into HI/LO, and raises the completion pulse consumed by the writeback stage as `exe_MD_complete`/`exe_MD_result`. It also drives the pipeline `stop` stall while an operation is in flight and a dependent or conflicting instruction is in execute.

## Interface
Parameters:
- MUL_CYCLES, 2, unit latency for MULT/MULTU; legal range 1..63
- DIV_CYCLES, 33, unit latency for DIV/DIVU; legal range 1..63

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- md_valid  in  1  MULT/MULTU/DIV/DIVU is in execute
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- md_a  in  32  rs operand
- md_b  in  32  rt operand
- mt_valid  in  1  MTHI/MTLO is in execute
- mt_sel  in  1  0 = LO, 1 = HI
- mt_data  in  32  value to write
- mf_valid  in  1  MFHI/MFLO is in execute
- unit_result  in  64  {HI, LO} from the arithmetic unit; sampled in the final RUN cycle
- unit_start  out  1  one-cycle launch pulse to the unit
- unit_op  out  2  latched md_op
- unit_a  out  32  latched md_a
- unit_b  out  32  latched md_b
- stop  out  1  pipeline stall
- busy  out  1  state == RUN
- md_complete  out  1  one-cycle completion pulse
- md_result  out  64  {HI, LO} captured at completion
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- There are two states, IDLE and RUN. A 6-bit down-counter `cnt` tracks RUN progress.
- **IDLE, md_valid=1:**
  - Latch md_op/md_a/md_b into unit_op/unit_a/unit_b.
  - Set cnt = (md_op[1] ? DIV_CYCLES : MUL_CYCLES) − 1.
  - Register unit_start=1 for the next cycle, then go to RUN.
- **IDLE, mt_valid=1 (and md_valid=0):** write mt_data into HI (mt_sel=1) or LO (mt_sel=0) at the edge. If md_valid and mt_valid are both high, md_valid wins and the mt write is dropped; one pipeline slot cannot carry both.
- **RUN, cnt≠0:** decrement cnt.
- **RUN, cnt==0:**
  - At the edge, load {hi, lo} and md_result from unit_result.
  - Register md_complete=1 for one cycle and return to IDLE.
- stop = busy & (md_valid | mf_valid | mt_valid). This is combinational and is never asserted in IDLE.
- Held requests are accepted in the first IDLE cycle after completion.
- Divide-by-zero: no special handling; whatever the unit returns is captured.
- Operands are stored and forwarded as raw bits; signedness is selected by unit_op only.
- unit_op/unit_a/unit_b hold their value until the next accept.

## Timing
- Reset values (asynchronous):
  - State is IDLE and cnt is 0.
  - unit_start, md_complete and stop are 0.
  - hi, lo, md_result, unit_op, unit_a and unit_b are 0.
- Reset during RUN aborts the operation; no completion pulse is generated.
- Let cycle 0 be the cycle in which md_valid is sampled in IDLE, and N the selected latency.
  - Cycles 1..N are RUN; busy=1 and unit_start=1 only in cycle 1.
  - unit_result must be valid in cycle N.
  - In cycle N+1: md_complete=1, md_result/hi/lo hold the new values, and the controller is back in IDLE.
- mf_valid in any of cycles 1..N is stalled and then reads the updated hi/lo in cycle N+1.
- Back-to-back MD: the second issue is accepted in cycle N+1, and its unit_start occurs in cycle N+2.
- N=1: a single RUN cycle with unit_start and result sampling in the same cycle.

## Test plan
- **MULT signed, MUL_CYCLES=2, bench unit returns signed product:** md_a=3, md_b=0xFFFFFFFE in cycle 0 -> unit_start in cycle 1; md_complete in cycle 3 with md_result=0xFFFFFFFF_FFFFFFFA, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- **DIVU 100/7, DIV_CYCLES=33:** -> busy for cycles 1..33; in cycle 34, lo=14, hi=2 and md_complete=1 for exactly one cycle.
- **MFHI held during a DIV:** mf_valid held high from cycle 2 -> stop=1 in cycles 2..33 and stop=0 in cycle 34, where the new hi is visible.
- **Back-to-back MULT then DIV:** DIV held at md_valid -> stop high until completion; DIV accepted in cycle N+1 and unit_start in cycle N+2 with the DIV operands.
- **MTLO 0x1234 in IDLE, plus a simultaneous md_valid+mt_valid:**
  - MTLO alone -> lo=0x1234 next cycle, hi unchanged, no md_complete.
  - Simultaneous case -> MD is launched and hi/lo are unchanged by the mt.
- **Reset asserted in cycle 10 of a DIV:** -> all outputs zero immediately; no md_complete follows; a new MULT issued after reset completes normally.
